// File: rtl/char_loop_mem_if.sv
// Character memory bus: handshake from the character latch, slot timing,
// clear control and the per-slot stream to the character generator.
interface char_loop_mem_if;
    logic       shift_en;
    logic [5:0] char_in;
    logic       char_valid;
    logic       char_ack;
    logic       clear_req;
    logic [5:0] char_out;
    logic       cursor_here;
    logic       ptr_zero;
    logic       busy;

    // Memory side
    modport slave (
        input  shift_en, char_in, char_valid, clear_req,
        output char_ack, char_out, cursor_here, ptr_zero, busy
    );

    // Latch / video timing side
    modport master (
        output shift_en, char_in, char_valid, clear_req,
        input  char_ack, char_out, cursor_here, ptr_zero, busy
    );
endinterface

// File: rtl/char_loop_mem.sv
// Recirculating 6-bit character page memory.
// A circular read pointer visits one slot per shift_en pulse. In RUN, a
// pending character is stored at the cursor slot (carriage return only moves
// the cursor). In CLEAR, one full revolution starting at slot 0 is
// overwritten with spaces, then the cursor homes and RUN resumes.
// At most one character is accepted per revolution, so a freshly moved
// cursor is first shown (and first usable) on the following revolution.
module char_loop_mem #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 24,
    parameter int         DEPTH      = 1024,
    parameter logic [5:0] CR_CODE    = 6'h0D,
    parameter logic [5:0] SPACE_CODE = 6'h20
) (
    input  logic           clk,
    input  logic           mr_n,
    char_loop_mem_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } state_t;

    state_t             state_q,       state_d;
    logic               armed_q,       armed_d;
    logic               busy_q,        busy_d;
    logic               wrote_q,       wrote_d;
    logic [PTR_W-1:0]   ptr_q,         ptr_d;
    logic [ROW_W-1:0]   row_q,         row_d;
    logic [COL_W-1:0]   col_q,         col_d;
    logic [5:0]         char_out_q,    char_out_d;
    logic               cursor_here_q, cursor_here_d;
    logic               ptr_zero_q,    ptr_zero_d;
    logic               char_ack_q,    char_ack_d;

    logic [5:0]         mem [DEPTH];
    logic [5:0]         rd_data;
    logic [5:0]         wr_data;
    logic [PTR_W-1:0]   cursor;
    logic [ROW_W-1:0]   row_inc;
    logic               slot_is_cursor;
    logic               slot_last;
    logic               run_hit;
    logic               store;
    logic               clr_wr;
    logic               mem_we;

    // Linear cursor slot from row/column; always below COLS*ROWS.
    assign cursor = PTR_W'(row_q) * PTR_W'(COLS) + PTR_W'(col_q);
    assign row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;

    // Decode what happens to the slot under the pointer this cycle.
    always_comb begin
        slot_is_cursor = (ptr_q == cursor);
        slot_last      = (ptr_q == PTR_W'(DEPTH - 1));
        rd_data        = mem[ptr_q];
        // A clear request in the same cycle pre-empts both a character
        // write and a clear write.
        run_hit = (state_q == ST_RUN) && bus.shift_en && slot_is_cursor &&
                  bus.char_valid && !bus.clear_req && !wrote_q;
        store   = run_hit && (bus.char_in != CR_CODE);
        clr_wr  = (state_q == ST_CLEAR) && bus.shift_en && !bus.clear_req &&
                  (armed_q || (ptr_q == '0));
        mem_we  = store || clr_wr;
        wr_data = clr_wr ? SPACE_CODE : bus.char_in;
    end

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every output of this block is given its held value first, so
        // no path through the branches below can leave one unassigned (latch).
        state_d       = state_q;
        armed_d       = armed_q;
        busy_d        = busy_q;
        wrote_d       = wrote_q;
        ptr_d         = ptr_q;
        row_d         = row_q;
        col_d         = col_q;
        char_out_d    = char_out_q;
        cursor_here_d = cursor_here_q;
        ptr_zero_d    = ptr_zero_q;
        char_ack_d    = 1'b0;

        if (bus.shift_en) begin
            char_out_d    = mem_we ? wr_data : rd_data;
            // Hidden for the rest of a revolution in which a character was
            // taken: the moved cursor becomes visible on the next pass.
            cursor_here_d = (state_q == ST_RUN) && slot_is_cursor && !wrote_q;
            ptr_zero_d    = (ptr_q == '0);
            ptr_d         = slot_last ? '0 : ptr_q + 1'b1;
            if (slot_last) begin
                wrote_d = 1'b0;
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    armed_d = 1'b0;
                    busy_d  = 1'b1;
                end else if (run_hit) begin
                    char_ack_d = 1'b1;
                    wrote_d    = 1'b1;
                    if (store && (col_q != COL_W'(COLS - 1))) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        row_d = row_inc;
                    end
                end
            end
            ST_CLEAR: begin
                if (bus.clear_req) begin
                    armed_d = 1'b0;
                end else if (clr_wr) begin
                    armed_d = 1'b1;
                    if (slot_last) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset starts a blanking pass.
    always_ff @(posedge clk or negedge mr_n) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!mr_n) begin
            state_q       <= ST_CLEAR;
            armed_q       <= 1'b1;
            busy_q        <= 1'b1;
            wrote_q       <= 1'b0;
            ptr_q         <= '0;
            row_q         <= '0;
            col_q         <= '0;
            char_out_q    <= '0;
            cursor_here_q <= 1'b0;
            ptr_zero_q    <= 1'b0;
            char_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            busy_q        <= busy_d;
            wrote_q       <= wrote_d;
            ptr_q         <= ptr_d;
            row_q         <= row_d;
            col_q         <= col_d;
            char_out_q    <= char_out_d;
            cursor_here_q <= cursor_here_d;
            ptr_zero_q    <= ptr_zero_d;
            char_ack_q    <= char_ack_d;
        end
    end

    // Character RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset; the CLEAR pass that follows every reset
        // blanks it, which keeps it mappable onto block RAM.
        if (mem_we) begin
            mem[ptr_q] <= wr_data;
        end
    end

    assign bus.char_out    = char_out_q;
    assign bus.cursor_here = cursor_here_q;
    assign bus.ptr_zero    = ptr_zero_q;
    assign bus.char_ack    = char_ack_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_char_loop_mem.sv
// Testbench for char_loop_mem: per-cycle comparison against a page-level
// reference model, a table of typed characters with their landing slots,
// and hand sequences for cursor wrap, clear and reset corners.
module tb_char_loop_mem;

    localparam int         COLS  = 40;
    localparam int         ROWS  = 24;
    localparam int         DEPTH = 1024;
    localparam logic [5:0] CR    = 6'h0D;
    localparam logic [5:0] SP    = 6'h20;

    logic clk;
    logic mr_n;

    char_loop_mem_if bus ();

    char_loop_mem #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .DEPTH     (DEPTH),
        .CR_CODE   (CR),
        .SPACE_CODE(SP)
    ) dut (
        .clk  (clk),
        .mr_n (mr_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model (screen page view) ----------------
    logic [5:0] ram [DEPTH];
    int         m_ptr, m_row, m_col;
    bit         m_clearing, m_armed, m_wrote;
    logic [5:0] m_out;
    bit         m_cur, m_zero, m_busy, m_ack;

    task automatic model_reset();
        m_ptr = 0; m_row = 0; m_col = 0;
        m_clearing = 1; m_armed = 1; m_wrote = 0;
        m_out = '0; m_cur = 0; m_zero = 0; m_busy = 1; m_ack = 0;
    endtask

    task automatic model_step(input bit sh, input bit v, input logic [5:0] c, input bit clr);
        int         slot;
        logic [5:0] shown;
        bit         at_cursor;
        m_ack = 0;
        if (sh) begin
            slot      = m_ptr;
            shown     = ram[slot];
            at_cursor = !m_clearing && !m_wrote && (slot == m_row * COLS + m_col);
            if (clr) begin
                // request handled below; nothing written this slot
            end else if (m_clearing) begin
                if (m_armed || slot == 0) begin
                    m_armed   = 1;
                    ram[slot] = SP;
                    shown     = SP;
                    if (slot == DEPTH - 1) begin
                        m_clearing = 0; m_row = 0; m_col = 0;
                    end
                end
            end else if (v && at_cursor) begin
                m_ack   = 1;
                m_wrote = 1;
                if (c == CR) begin
                    m_col = 0;
                    m_row = (m_row + 1) % ROWS;
                end else begin
                    ram[slot] = c;
                    shown     = c;
                    m_col     = m_col + 1;
                    if (m_col == COLS) begin
                        m_col = 0;
                        m_row = (m_row + 1) % ROWS;
                    end
                end
            end
            if (slot == DEPTH - 1) m_wrote = 0;
            m_out  = shown;
            m_cur  = at_cursor;
            m_zero = (slot == 0);
            m_ptr  = (slot + 1) % DEPTH;
        end
        if (clr) begin
            m_clearing = 1;
            m_armed    = 0;
        end
        m_busy = m_clearing;
    endtask

    // One clock: drive, advance model, compare all outputs after the edge.
    task automatic step(input bit sh, input bit clr);
        bus.shift_en  = sh;
        bus.clear_req = clr;
        model_step(sh, bus.char_valid, bus.char_in, clr);
        @(posedge clk);
        #1;
        check("cycle_outputs",
              {22'd0, bus.char_ack, bus.busy, bus.ptr_zero, bus.cursor_here, bus.char_out},
              {22'd0, m_ack, m_busy, m_zero, m_cur, m_out});
        bus.shift_en  = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    // Present a character and shift until it is acknowledged (bounded).
    task automatic type_char(input logic [5:0] c, output int slot, output logic [5:0] shown);
        int  s;
        bit  got;
        got   = 0;
        slot  = -1;
        shown = '0;
        bus.char_valid = 1'b1;
        bus.char_in    = c;
        for (int n = 0; n < 3 * DEPTH && !got; n++) begin
            s = m_ptr;
            step(1'b1, 1'b0);
            if (bus.char_ack) begin
                got   = 1;
                slot  = s;
                shown = bus.char_out;
            end
        end
        bus.char_valid = 1'b0;
    endtask

    typedef struct {
        logic [5:0] ch;
        int         exp_slot;
        logic [5:0] exp_out;
    } type_vec_t;

    type_vec_t  vecs [8];
    int         slot;
    logic [5:0] shown;
    bit         ok;
    bit         sh, clr;

    initial begin
        vecs[0] = '{6'h01, 0,  6'h01};   // first character at home
        vecs[1] = '{6'h05, 1,  6'h05};
        vecs[2] = '{6'h06, 2,  6'h06};
        vecs[3] = '{6'h07, 3,  6'h07};
        vecs[4] = '{6'h08, 4,  6'h08};
        vecs[5] = '{6'h01, 5,  6'h01};   // 'A' at column 5
        vecs[6] = '{CR,    6,  SP};      // CR acked, not stored
        vecs[7] = '{6'h02, 40, 6'h02};   // lands on row 1 column 0

        for (int i = 0; i < DEPTH; i++) ram[i] = 6'h3F;
        mr_n = 1'b0;
        bus.shift_en = 1'b0; bus.char_in = '0; bus.char_valid = 1'b0; bus.clear_req = 1'b0;
        model_reset();
        #12;
        check("reset_outputs",
              {22'd0, bus.char_ack, bus.busy, bus.ptr_zero, bus.cursor_here, bus.char_out},
              {22'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00});
        @(negedge clk);
        mr_n = 1'b1;

        // T1: blanking pass after reset
        ok = 1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b1, 1'b0);
            if (bus.char_out !== SP) ok = 0;
        end
        check("t1_busy_before_last", bus.busy, 1);
        step(1'b1, 1'b0);
        if (bus.char_out !== SP) ok = 0;
        check("t1_busy_fall", bus.busy, 0);
        check("t1_all_space", ok, 1);

        // T2/T3: typed characters land at expected slots
        for (int i = 0; i < 8; i++) begin
            type_char(vecs[i].ch, slot, shown);
            check($sformatf("type%0d_slot", i), slot, vecs[i].exp_slot);
            check($sformatf("type%0d_out", i), shown, vecs[i].exp_out);
            if (i == 0) begin
                step(1'b1, 1'b0);                      // slot 1, same revolution
                check("t2_cursor_hidden", bus.cursor_here, 0);
                for (int k = 2; k < DEPTH; k++) step(1'b1, 1'b0);
                step(1'b1, 1'b0);                      // slot 0
                check("t2_ptr_zero", bus.ptr_zero, 1);
                step(1'b1, 1'b0);                      // slot 1, next revolution
                check("t2_cursor_next_rev", bus.cursor_here, 1);
            end
        end

        // T4: drive cursor to slot 959 with CRs and random characters
        for (int i = 0; i < 22; i++) type_char(CR, slot, shown);
        for (int i = 0; i < 39; i++) begin
            logic [5:0] c;
            c = 6'($urandom_range(0, 63));
            if (c == CR) c = 6'h0E;
            type_char(c, slot, shown);
        end
        type_char(6'h11, slot, shown);
        check("t4_last_slot", slot, 959);
        ok = 1;
        for (int i = 960; i < DEPTH; i++) begin
            step(1'b1, 1'b0);
            if (bus.char_out !== SP || bus.char_ack !== 1'b0) ok = 0;
        end
        check("t4_tail_untouched", ok, 1);
        type_char(6'h12, slot, shown);
        check("t4_wrap_slot", slot, 0);

        // T5: clear and pending character in the same cycle at the cursor
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);                              // slot 0, cursor is 1
        bus.char_valid = 1'b1;
        bus.char_in    = 6'h15;
        step(1'b1, 1'b1);                              // slot 1 == cursor
        check("t5_no_ack", bus.char_ack, 0);
        check("t5_busy", bus.busy, 1);
        type_char(6'h15, slot, shown);
        check("t5_slot_after_clear", slot, 0);
        check("t5_not_busy", bus.busy, 0);

        // T6: reset mid-revolution with a character pending
        bus.char_valid = 1'b1;
        bus.char_in    = 6'h2A;
        ok = 1;
        while (m_ptr != 500) begin
            step(1'b1, 1'b0);
            if (bus.char_ack !== 1'b0) ok = 0;
        end
        check("t6_still_pending", ok, 1);
        #2;
        mr_n = 1'b0;
        model_reset();
        #1;
        check("t6_reset_outputs",
              {22'd0, bus.char_ack, bus.busy, bus.ptr_zero, bus.cursor_here, bus.char_out},
              {22'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00});
        bus.shift_en = 1'b1;
        @(posedge clk);
        #1;
        check("t6_held_in_reset", {bus.busy, bus.char_out}, {1'b1, 6'h00});
        bus.shift_en = 1'b0;
        #2;
        mr_n = 1'b1;
        step(1'b1, 1'b0);
        check("t6_ptr_restart", bus.ptr_zero, 1);
        type_char(6'h2A, slot, shown);
        check("t6_char_after_clear", slot, 0);

        // Randomised traffic against the model
        bus.char_valid = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            sh  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 1499) == 0);
            if (!bus.char_valid && $urandom_range(0, 3) == 0) begin
                bus.char_valid = 1'b1;
                bus.char_in    = ($urandom_range(0, 7) == 0) ? CR : 6'($urandom_range(0, 63));
            end else if (bus.char_valid && $urandom_range(0, 299) == 0) begin
                bus.char_valid = 1'b0;
            end
            step(sh, clr);
            if (m_ack) bus.char_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
